// File: rtl/updown_count_arbiter.sv
// rtl/updown_count_arbiter.sv - round-robin arbiter sharing one up/down burst counter
// Optional macro SAT_EN: counter saturates at 0 / all-ones instead of wrapping.
module updown_count_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 32,
   parameter int BURST_W = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ-1:0]         inst_i,
   input  logic [NUM_REQ*BURST_W-1:0] len_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [NUM_REQ-1:0]         done_o,
   output logic                       busy_o,
   output logic [WIDTH-1:0]           value_o
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int REM_W = BURST_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   logic [0:0]         state_q,  state_d;
   logic [PTR_W-1:0]   ptr_q,    ptr_d;
   logic [PTR_W-1:0]   winner_q, winner_d;
   logic               dir_q,    dir_d;
   logic [REM_W-1:0]   remain_q, remain_d;
   logic [WIDTH-1:0]   value_q,  value_d;
   logic [NUM_REQ-1:0] grant_q,  grant_d;
   logic [NUM_REQ-1:0] done_q,   done_d;
   logic               busy_q,   busy_d;

   logic               win_found;
   logic [PTR_W-1:0]   win_idx;
   logic [BURST_W-1:0] win_len;
   logic [WIDTH-1:0]   step_value;
   int                 cand;

   // Scan from the highest offset down so the lowest offset from the pointer wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         cand = (int'(ptr_q) + off) % NUM_REQ;
         if (req_i[cand]) begin
            win_found = 1'b1;
            win_idx   = PTR_W'(cand);
         end
      end
   end

   assign win_len = len_i[int'(win_idx) * BURST_W +: BURST_W];

   always_comb begin
      step_value = value_q;
      if (!dir_q) begin
`ifdef SAT_EN
         if (value_q != {WIDTH{1'b1}}) begin
            step_value = value_q + WIDTH'(1);
         end
`else
         step_value = value_q + WIDTH'(1);
`endif
      end else begin
`ifdef SAT_EN
         if (value_q != '0) begin
            step_value = value_q - WIDTH'(1);
         end
`else
         step_value = value_q - WIDTH'(1);
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      winner_d = winner_q;
      dir_d    = dir_q;
      remain_d = remain_q;
      value_d  = value_q;
      grant_d  = grant_q;
      done_d   = '0;
      busy_d   = busy_q;

      case (state_q)
         ST_IDLE: begin
            grant_d = '0;
            busy_d  = 1'b0;
            if (win_found) begin
               state_d          = ST_RUN;
               winner_d         = win_idx;
               dir_d            = inst_i[win_idx];
               remain_d         = REM_W'(win_len) + REM_W'(1);
               grant_d[win_idx] = 1'b1;
               busy_d           = 1'b1;
            end
         end
         ST_RUN: begin
            value_d  = step_value;
            remain_d = remain_q - REM_W'(1);
            if (remain_q == REM_W'(1)) begin
               state_d          = ST_IDLE;
               grant_d          = '0;
               done_d[winner_q] = 1'b1;
               busy_d           = 1'b0;
               ptr_d            = (winner_q == LAST_IDX) ? '0 : winner_q + PTR_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         winner_q <= '0;
         dir_q    <= 1'b0;
         remain_q <= '0;
         value_q  <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         winner_q <= winner_d;
         dir_q    <= dir_d;
         remain_q <= remain_d;
         value_q  <= value_d;
         grant_q  <= grant_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   assign grant_o = grant_q;
   assign done_o  = done_q;
   assign busy_o  = busy_q;
   assign value_o = value_q;

endmodule

// File: tb/tb_updown_count_arbiter.sv
// tb/tb_updown_count_arbiter.sv - directed table and corner sequences for updown_count_arbiter
module tb_updown_count_arbiter;

   logic        clk;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  inst;
   logic [15:0] len;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        busy;
   logic [31:0] value;

   int n_checks = 0;
   int n_errors = 0;

   updown_count_arbiter #(
      .NUM_REQ(4),
      .WIDTH  (32),
      .BURST_W(4)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .req_i  (req),
      .inst_i (inst),
      .len_i  (len),
      .grant_o(grant),
      .done_o (done),
      .busy_o (busy),
      .value_o(value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  req;
      logic [3:0]  inst;
      logic [15:0] len;
      logic [3:0]  grant;
      logic [3:0]  done;
      logic        busy;
      logic [31:0] value;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [3:0] r, input logic [3:0] i, input logic [15:0] l);
      @(negedge clk);
      req  = r;
      inst = i;
      len  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                          input logic b, input logic [31:0] v);
      chk({tag, ".grant"}, 32'(grant), 32'(g));
      chk({tag, ".done"},  32'(done),  32'(d));
      chk({tag, ".busy"},  32'(busy),  32'(b));
      chk({tag, ".value"}, value, v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      req  = '0;
      inst = '0;
      len  = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] wrap_exp;

      // req, inst, len, grant, done, busy, value (after the edge)
      vecs[0]  = '{4'b0001, 4'b0000, 16'h0002, 4'b0001, 4'b0000, 1'b1, 32'd0};
      vecs[1]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 1'b1, 32'd1};
      vecs[2]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 1'b1, 32'd2};
      vecs[3]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0001, 1'b0, 32'd3};
      vecs[4]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 32'd3};
      vecs[5]  = '{4'b0010, 4'b0010, 16'h0010, 4'b0010, 4'b0000, 1'b1, 32'd3};
      vecs[6]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0010, 4'b0000, 1'b1, 32'd2};
      vecs[7]  = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0010, 1'b0, 32'd1};
      vecs[8]  = '{4'b0101, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 32'd1};
      vecs[9]  = '{4'b0101, 4'b0000, 16'h0000, 4'b0000, 4'b0100, 1'b0, 32'd2};
      vecs[10] = '{4'b0101, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 1'b1, 32'd2};
      vecs[11] = '{4'b0100, 4'b0000, 16'h0000, 4'b0000, 4'b0001, 1'b0, 32'd3};
      vecs[12] = '{4'b0100, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 32'd3};
      vecs[13] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0100, 1'b0, 32'd4};
      vecs[14] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 32'd4};
      vecs[15] = '{4'b1111, 4'b0000, 16'h0000, 4'b1000, 4'b0000, 1'b1, 32'd4};
      vecs[16] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'b1000, 1'b0, 32'd5};
      vecs[17] = '{4'b1111, 4'b0000, 16'h0000, 4'b0001, 4'b0000, 1'b1, 32'd5};
      vecs[18] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'b0001, 1'b0, 32'd6};
      vecs[19] = '{4'b1111, 4'b0000, 16'h0000, 4'b0010, 4'b0000, 1'b1, 32'd6};
      vecs[20] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'b0010, 1'b0, 32'd7};
      vecs[21] = '{4'b1111, 4'b0000, 16'h0000, 4'b0100, 4'b0000, 1'b1, 32'd7};
      vecs[22] = '{4'b1111, 4'b0000, 16'h0000, 4'b0000, 4'b0100, 1'b0, 32'd8};
      vecs[23] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 4'b0000, 1'b0, 32'd8};

      rst  = 1'b1;
      req  = '0;
      inst = '0;
      len  = '0;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 4'b0000, 4'b0000, 1'b0, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 24; k++) begin
         cyc(vecs[k].req, vecs[k].inst, vecs[k].len);
         chk_all($sformatf("vec%0d", k), vecs[k].grant, vecs[k].done, vecs[k].busy, vecs[k].value);
      end

      // Down step from 0: wraps, or holds at 0 when saturating.
      do_reset();
`ifdef SAT_EN
      wrap_exp = 32'd0;
`else
      wrap_exp = 32'hFFFF_FFFF;
`endif
      cyc(4'b0001, 4'b0001, 16'h0000);
      chk_all("wrap.grant", 4'b0001, 4'b0000, 1'b1, 32'd0);
      cyc(4'b0000, 4'b0000, 16'h0000);
      chk_all("wrap.done", 4'b0000, 4'b0001, 1'b0, wrap_exp);

      // Eight-step burst; req dropped and inst/len changed mid-burst.
      do_reset();
      cyc(4'b0001, 4'b0000, 16'h0007);
      chk_all("long.start", 4'b0001, 4'b0000, 1'b1, 32'd0);
      for (int s = 1; s <= 8; s++) begin
         if (s <= 2) cyc(4'b0001, 4'b0001, 16'h0000);
         else        cyc(4'b0000, 4'b1111, 16'h0000);
         if (s < 8) chk_all($sformatf("long.s%0d", s), 4'b0001, 4'b0000, 1'b1, 32'(s));
         else       chk_all("long.end", 4'b0000, 4'b0001, 1'b0, 32'd8);
      end

      // Build value 5, start another burst, then reset asynchronously mid-burst.
      do_reset();
      cyc(4'b0001, 4'b0000, 16'h0004);
      repeat (5) cyc(4'b0000, 4'b0000, 16'h0000);
      chk_all("pre.done", 4'b0000, 4'b0001, 1'b0, 32'd5);
      cyc(4'b0001, 4'b0000, 16'h0003);
      chk_all("mid.start", 4'b0001, 4'b0000, 1'b1, 32'd5);
      @(negedge clk);
      req = '0;
      #2;
      rst = 1'b1;
      #1;
      chk_all("async.rst", 4'b0000, 4'b0000, 1'b0, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int s = 0; s < 4; s++) begin
         cyc(4'b0000, 4'b0000, 16'h0000);
         chk_all($sformatf("post.rst%0d", s), 4'b0000, 4'b0000, 1'b0, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
